// File: rtl/dac_seg_driver_if.sv
// Sample bus for the segmented DAC driver: the sample code and strobe go in,
// and the registered row/column element enables come out.
interface dac_seg_driver_if #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4
);
  localparam int N_ROW = (1 << ROW_BITS) - 1;
  localparam int N_COL = (1 << COL_BITS) - 1;

  // Handshake: DAC_IN/DWA_EN are taken on every CLK edge where DAC_VALID=1.
  // There is no ready; the driver accepts one sample per cycle unconditionally.
  // OUT_VALID pulses for exactly the cycle in which ROWS/COLS first show a new
  // sample, and the outputs hold their value between pulses.
  logic [ROW_BITS+COL_BITS-1:0] DAC_IN;
  logic                         DAC_VALID;
  logic                         DWA_EN;
  logic [N_ROW-1:0]             ROWS;
  logic [N_COL-1:0]             COLS;
  logic                         OUT_VALID;
  logic [COL_BITS-1:0]          DWA_PTR;

  modport master (
    output DAC_IN, DAC_VALID, DWA_EN,
    input  ROWS, COLS, OUT_VALID, DWA_PTR
  );

  modport slave (
    input  DAC_IN, DAC_VALID, DWA_EN,
    output ROWS, COLS, OUT_VALID, DWA_PTR
  );
endinterface

// File: rtl/dac_seg_driver.sv
// Segmented DAC element driver. The upper bits of the code are decoded to a
// row thermometer. The lower bits are decoded either to a static column
// thermometer or to a data-weighted-averaging (DWA) pattern. In the DWA
// pattern the energised columns form a contiguous run that starts at a
// rotating pointer. There are two register stages: capture, then encode.
module dac_seg_driver #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  dac_seg_driver_if.slave  bus
);
  localparam int N_ROW = (1 << ROW_BITS) - 1;
  localparam int N_COL = (1 << COL_BITS) - 1;
  localparam logic [COL_BITS:0] N_COL_W = N_COL[COL_BITS:0];

  logic [ROW_BITS-1:0] s1_row_q;
  logic [COL_BITS-1:0] s1_col_q;
  logic                s1_dwa_q;
  logic                s1_vld_q;

  logic [N_ROW-1:0]    rows_q, rows_d;
  logic [N_COL-1:0]    cols_q, cols_d;
  logic [COL_BITS-1:0] ptr_q, ptr_d;
  logic                ovld_q;

  logic [N_COL-1:0]    col_therm;
  logic [2*N_COL-1:0]  col_dbl;
  logic [COL_BITS:0]   ptr_sum;

  // Stage 1: capture the sample and its mode. The data is held while idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_row_q <= '0;
      s1_col_q <= '0;
      s1_dwa_q <= 1'b0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= bus.DAC_VALID;
      if (bus.DAC_VALID) begin
        s1_row_q <= bus.DAC_IN[ROW_BITS+COL_BITS-1:COL_BITS];
        s1_col_q <= bus.DAC_IN[COL_BITS-1:0];
        s1_dwa_q <= bus.DWA_EN;
      end
    end
  end

  // Encode the captured sample: row thermometer, column pattern, next pointer.
  always_comb begin
    rows_d    = ~({N_ROW{1'b1}} << s1_row_q);
    col_therm = ~({N_COL{1'b1}} << s1_col_q);
    // Rotating the thermometer left by ptr, modulo N_COL, is the same as
    // shifting it into a double-width word and folding the high half back in.
    // The result is always a contiguous run of elements. Full scale gives all
    // ones and zero gives all zeros, whatever the pointer.
    col_dbl   = {{N_COL{1'b0}}, col_therm} << ptr_q;
    ptr_sum   = {1'b0, ptr_q} + {1'b0, s1_col_q};
    cols_d    = col_therm;
    ptr_d     = '0;
    if (s1_dwa_q) begin
      cols_d = col_dbl[N_COL-1:0] | col_dbl[2*N_COL-1:N_COL];
      // ptr < N_COL and col <= N_COL, so a single subtraction is enough.
      // A code of 0 or of N_COL therefore leaves the pointer where it was.
      ptr_d  = (ptr_sum >= N_COL_W) ? COL_BITS'(ptr_sum - N_COL_W)
                                    : COL_BITS'(ptr_sum);
    end
  end

  // Stage 2: update the outputs only when stage 1 holds a new sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rows_q <= '0;
      cols_q <= '0;
      ptr_q  <= '0;
      ovld_q <= 1'b0;
    end else begin
      ovld_q <= s1_vld_q;
      if (s1_vld_q) begin
        rows_q <= rows_d;
        cols_q <= cols_d;
        ptr_q  <= ptr_d;
      end
    end
  end

  assign bus.ROWS      = rows_q;
  assign bus.COLS      = cols_q;
  assign bus.DWA_PTR   = ptr_q;
  assign bus.OUT_VALID = ovld_q;
endmodule

// File: tb/tb_dac_seg_driver.sv
// Bench for dac_seg_driver with ROW_BITS=4 and COL_BITS=4. It drives directed
// and randomized samples and compares the outputs after every edge against a
// reference model of the element-selection rules.
module tb_dac_seg_driver;
  localparam int RB = 4;
  localparam int CB = 4;
  localparam int N_ROW = (1 << RB) - 1;
  localparam int N_COL = (1 << CB) - 1;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  dac_seg_driver_if #(.ROW_BITS(RB), .COL_BITS(CB)) bus ();

  dac_seg_driver #(.ROW_BITS(RB), .COL_BITS(CB)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the accepted samples waiting to appear, {dwa, row, col},
  // and the expected output state.
  logic [8:0]  exp_q[$];
  logic [31:0] m_rows;
  logic [31:0] m_cols;
  int          m_ptr;
  logic        m_ov;

  // Apply one sample using the element-selection rules directly.
  task automatic model_apply(input logic [8:0] s);
    int row;
    int col;
    int d;
    row    = int'(s[7:4]);
    col    = int'(s[3:0]);
    m_rows = '0;
    m_cols = '0;
    for (int i = 0; i < N_ROW; i++) m_rows[i] = (i < row);
    if (s[8]) begin
      for (int i = 0; i < N_COL; i++) begin
        d = ((i - m_ptr) % N_COL + N_COL) % N_COL;
        m_cols[i] = (d < col);
      end
      m_ptr = (m_ptr + col) % N_COL;
    end else begin
      for (int i = 0; i < N_COL; i++) m_cols[i] = (i < col);
      m_ptr = 0;
    end
    m_ov = 1'b1;
  endtask

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present the inputs, take one edge, update the model, then check.
  task automatic tick(input logic rst, input logic vld, input logic [7:0] din, input logic dwa);
    RST           = rst;
    bus.DAC_VALID = vld;
    bus.DAC_IN    = din;
    bus.DWA_EN    = dwa;
    @(posedge CLK);
    if (rst) begin
      exp_q.delete();
      m_rows = '0;
      m_cols = '0;
      m_ptr  = 0;
      m_ov   = 1'b0;
    end else begin
      m_ov = 1'b0;
      if (exp_q.size() > 0) model_apply(exp_q.pop_front());
      if (vld) exp_q.push_back({dwa, din});
    end
    #1;
    chk("rows",      32'(bus.ROWS),      m_rows);
    chk("cols",      32'(bus.COLS),      m_cols);
    chk("dwa_ptr",   32'(bus.DWA_PTR),   32'(m_ptr));
    chk("out_valid", 32'(bus.OUT_VALID), 32'(m_ov));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 8'($urandom), 1'($urandom));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_rows = '0;
    m_cols = '0;
    m_ptr  = 0;
    m_ov   = 1'b0;

    // Reset with random traffic on the inputs: everything stays zero.
    for (int k = 0; k < 2; k++) tick(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
    chk("rst_rows", 32'(bus.ROWS), 32'h0);
    chk("rst_ptr",  32'(bus.DWA_PTR), 32'h0);

    // Static sample 0x5A: the outputs show it two edges later and then hold.
    tick(1'b0, 1'b1, 8'h5A, 1'b0);
    chk("s5a_ov_early", 32'(bus.OUT_VALID), 32'h0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("s5a_rows", 32'(bus.ROWS), 32'h001F);
    chk("s5a_cols", 32'(bus.COLS), 32'h03FF);
    chk("s5a_ov",   32'(bus.OUT_VALID), 32'h1);
    idle(2);
    chk("s5a_hold", 32'(bus.COLS), 32'h03FF);

    // DWA rotation with back-to-back codes 5, 5, 7.
    tick(1'b0, 1'b1, 8'h05, 1'b1);
    tick(1'b0, 1'b1, 8'h05, 1'b1);
    chk("dwa1_cols", 32'(bus.COLS), 32'h001F);
    chk("dwa1_ptr",  32'(bus.DWA_PTR), 32'd5);
    tick(1'b0, 1'b1, 8'h07, 1'b1);
    chk("dwa2_cols", 32'(bus.COLS), 32'h03E0);
    chk("dwa2_ptr",  32'(bus.DWA_PTR), 32'd10);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("dwa3_cols", 32'(bus.COLS), 32'h7C03);
    chk("dwa3_ptr",  32'(bus.DWA_PTR), 32'd2);

    // Ten idle cycles: the outputs hold and OUT_VALID stays low.
    idle(10);
    chk("idle_cols", 32'(bus.COLS), 32'h7C03);

    // Move the pointer to 7, then send full scale, then a static sample.
    tick(1'b0, 1'b1, 8'h05, 1'b1);
    tick(1'b0, 1'b1, 8'hFF, 1'b1);
    chk("to7_ptr", 32'(bus.DWA_PTR), 32'd7);
    tick(1'b0, 1'b1, 8'h03, 1'b0);
    chk("fs_rows", 32'(bus.ROWS), 32'h7FFF);
    chk("fs_cols", 32'(bus.COLS), 32'h7FFF);
    chk("fs_ptr",  32'(bus.DWA_PTR), 32'd7);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("st_cols", 32'(bus.COLS), 32'h0007);
    chk("st_ptr",  32'(bus.DWA_PTR), 32'd0);

    // Build a nonzero pointer, then accept a sample and reset on the next edge.
    tick(1'b0, 1'b1, 8'h09, 1'b1);
    tick(1'b0, 1'b1, 8'h35, 1'b1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rstmid_ov",   32'(bus.OUT_VALID), 32'h0);
    chk("rstmid_cols", 32'(bus.COLS), 32'h0);
    tick(1'b0, 1'b1, 8'h03, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("post_rst_cols", 32'(bus.COLS), 32'h0007);
    chk("post_rst_ptr",  32'(bus.DWA_PTR), 32'd3);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
